mutative_line_responder: RTL

Synthesizable backing-memory responder for the downward-facing port of `mutative_cache`, one line (256 bits) per transaction. It answers `dfp_read`/`dfp_write` requests after a fixed programmable latency, stores lines in an internal array, and flags protocol violations. It is used as the memory model in cache-level benches and as the on-chip backing store in small integration builds.

---
 rtl/mutative_line_responder_pkg.sv | 14 +
 rtl/mutative_line_responder_line_store.sv | 32 +++
 rtl/mutative_line_responder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mutative_line_responder_pkg.sv
// Shared types for the mutative cache backing-memory responder:
// line width, offset width and the responder FSM state encoding.
package mutative_types;

    localparam int LINE_BITS   = 256;
    localparam int OFFSET_BITS = 5;

    typedef logic [1:0] line_resp_state_t;

    localparam line_resp_state_t RS_IDLE = 2'd0;
    localparam line_resp_state_t RS_BUSY = 2'd1;
    localparam line_resp_state_t RS_RESP = 2'd2;

endpackage

// File: rtl/mutative_line_responder_line_store.sv
// Flop-based line array: synchronous clear on reset, one write port,
// one asynchronous read port.
module line_store
    import mutative_types::*;
#(
    parameter int DEPTH_LINES = 64,
    parameter int IDX_W       = $clog2(DEPTH_LINES)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 we_i,
    input  logic [IDX_W-1:0]     waddr_i,
    input  logic [LINE_BITS-1:0] wdata_i,
    input  logic [IDX_W-1:0]     raddr_i,
    output logic [LINE_BITS-1:0] rdata_o
);

    logic [LINE_BITS-1:0] mem_q [DEPTH_LINES];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH_LINES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mutative_line_responder.sv
// Backing-memory responder for the mutative cache downward port: fixed
// latency line reads/writes with a sticky protocol-violation checker.
module mutative_line_responder
    import mutative_types::*;
#(
    parameter int DEPTH_LINES = 64,
    parameter int LATENCY     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          dfp_addr,
    input  logic                 dfp_read,
    input  logic                 dfp_write,
    input  logic [LINE_BITS-1:0] dfp_wdata,
    output logic [LINE_BITS-1:0] dfp_rdata,
    output logic                 dfp_resp,
    output logic                 protocol_err
);

    localparam int IDX_W = $clog2(DEPTH_LINES);
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam int TAG_W = 32 - OFFSET_BITS;

    line_resp_state_t     state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 is_wr_q, is_wr_d;
    logic [TAG_W-1:0]     addr_q, addr_d;
    logic [LINE_BITS-1:0] wdata_q, wdata_d;
    logic                 resp_q, resp_d;
    logic [LINE_BITS-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;

    logic                 mismatch;
    logic                 rd_now;
    logic                 store_we;
    logic [IDX_W-1:0]     rd_idx;
    logic [LINE_BITS-1:0] store_rdata;
    logic                 unused_offset_bits;

    assign unused_offset_bits = ^dfp_addr[OFFSET_BITS-1:0];

    // Any deviation from the latched request while it is outstanding.
    assign mismatch = (dfp_read != !is_wr_q) || (dfp_write != is_wr_q)
                   || (dfp_addr[31:OFFSET_BITS] != addr_q)
                   || (is_wr_q && (dfp_wdata != wdata_q));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        case (state_q)
            RS_IDLE: begin
                if (dfp_read && dfp_write) begin
                    err_d = 1'b1;
                end else if (dfp_read || dfp_write) begin
                    is_wr_d = dfp_write;
                    addr_d  = dfp_addr[31:OFFSET_BITS];
                    wdata_d = dfp_wdata;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? RS_RESP : RS_BUSY;
                end
            end
            RS_BUSY: begin
                if (mismatch) err_d = 1'b1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) state_d = RS_RESP;
            end
            RS_RESP: begin
                if (mismatch) err_d = 1'b1;
                state_d = RS_IDLE;
            end
            default: state_d = RS_IDLE;
        endcase
    end

    // Outputs are registered on the edge that enters RESP, so the read index
    // comes straight from the request when LATENCY==1 skips BUSY.
    assign rd_idx   = (state_q == RS_IDLE) ? dfp_addr[OFFSET_BITS +: IDX_W]
                                           : addr_q[IDX_W-1:0];
    assign rd_now   = (state_q == RS_IDLE) ? dfp_read : !is_wr_q;
    assign resp_d   = (state_d == RS_RESP);
    assign rdata_d  = (resp_d && rd_now) ? store_rdata : '0;
    assign store_we = (state_q == RS_RESP) && is_wr_q;

    line_store #(
        .DEPTH_LINES(DEPTH_LINES),
        .IDX_W      (IDX_W)
    ) u_store (
        .clk_i  (clk),
        .rst_i  (rst),
        .we_i   (store_we),
        .waddr_i(addr_q[IDX_W-1:0]),
        .wdata_i(wdata_q),
        .raddr_i(rd_idx),
        .rdata_o(store_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RS_IDLE;
            cnt_q   <= '0;
            is_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign dfp_resp     = resp_q;
    assign dfp_rdata    = rdata_q;
    assign protocol_err = err_q;

endmodule
